// File: rtl/prod_acc_pkg.sv
// Shared types and helpers for the product accumulator.
// Saturation limits are returned as 64-bit patterns; callers truncate them
// to their accumulator width.
package prod_acc_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCUM
  } acc_state_e;

  // Largest representable value at the given width.
  function automatic logic [63:0] sat_max(input int unsigned width, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed) return ones >> (65 - width);
    return ones >> (64 - width);
  endfunction

  // Smallest representable value at the given width (two's-complement pattern).
  function automatic logic [63:0] sat_min(input int unsigned width, input bit is_signed);
    if (is_signed) return 64'd1 << (width - 1);
    return '0;
  endfunction

endpackage

// File: rtl/prod_accumulator_if.sv
// Handshake and data bundle between the upstream multiplier, the
// accumulator and the downstream consumer of completed sums.
interface prod_accumulator_if #(
  parameter int WIDTHP   = 16,
  parameter int WIDTHACC = 20
);
  logic                i_clken;
  logic                i_in_valid;
  logic [WIDTHP-1:0]   i_product;
  logic                o_clken;
  logic                o_out_valid;
  logic                i_out_ready;
  logic [WIDTHACC-1:0] o_sum;
  logic                o_overflow;
  logic                o_busy;

  // Upstream/downstream side of the bundle.
  modport master (
    output i_clken, i_in_valid, i_product, i_out_ready,
    input  o_clken, o_out_valid, o_sum, o_overflow, o_busy
  );

  // Accumulator side of the bundle.
  modport slave (
    input  i_clken, i_in_valid, i_product, i_out_ready,
    output o_clken, o_out_valid, o_sum, o_overflow, o_busy
  );
endinterface

// File: rtl/prod_acc_valid_dly.sv
// Enable-gated valid delay line that tracks operands through the upstream
// multiplier so the aligned valid arrives with its product.
module prod_acc_valid_dly #(
  parameter int PIPELINE = 2
) (
  input  logic i_clock,
  input  logic i_aclr,
  input  logic i_en,
  input  logic i_valid,
  output logic o_valid,
  output logic o_any
);

  if (PIPELINE == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{i_clock, i_aclr, i_en};
    assign o_valid   = i_valid;
    assign o_any     = 1'b0;
  end else begin : g_line
    logic [PIPELINE-1:0] dly_q, dly_d;

    // Shift the valid one stage per enabled clock; hold otherwise.
    always_comb begin
      dly_d = dly_q;
      if (i_en) begin
        dly_d[0] = i_valid;
        for (int unsigned i = 1; i < PIPELINE; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    // Delay-line registers.
    always_ff @(posedge i_clock or posedge i_aclr) begin
      if (i_aclr) dly_q <= '0;
      else        dly_q <= dly_d;
    end

    assign o_valid = dly_q[PIPELINE-1];
    assign o_any   = |dly_q;
  end

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates NUM_TERMS multiplier products into one result with a
// valid/ready output and back-pressure onto the multiplier clock enable.
// Optional macro PROD_ACCUMULATOR_SAT_EN: clamp the accumulator on
// overflow instead of wrapping.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int WIDTHP    = 16,
  parameter int WIDTHACC  = 20,
  parameter int NUM_TERMS = 4,
  parameter int PIPELINE  = 2,
  parameter bit SIGNED    = 1'b1
) (
  input logic              i_clock,
  input logic              i_aclr,
  prod_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

`ifdef PROD_ACCUMULATOR_SAT_EN
  localparam logic [WIDTHACC-1:0] SAT_MAX = WIDTHACC'(sat_max(WIDTHACC, SIGNED));
  localparam logic [WIDTHACC-1:0] SAT_MIN = WIDTHACC'(sat_min(WIDTHACC, SIGNED));
`endif

  acc_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTHACC-1:0] acc_q, acc_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [WIDTHACC-1:0] sum_q, sum_d;
  logic                out_valid_q, out_valid_d;
  logic                overflow_q, overflow_d;

  logic                stall, clken, av, dly_any, adv, last_term;
  logic [WIDTHACC-1:0] ext_p, base, new_acc;
  logic [WIDTHACC:0]   sum_wide;
  logic                add_ovf;

  assign stall = out_valid_q & ~bus.i_out_ready;
  assign clken = bus.i_clken & ~stall;
  assign adv   = clken & av;

  prod_acc_valid_dly #(.PIPELINE(PIPELINE)) u_valid_dly (
    .i_clock (i_clock),
    .i_aclr  (i_aclr),
    .i_en    (clken),
    .i_valid (bus.i_in_valid),
    .o_valid (av),
    .o_any   (dly_any)
  );

  // Extend the product, add it to the running partial and detect/handle overflow.
  always_comb begin
    if (SIGNED) ext_p = WIDTHACC'($signed(bus.i_product));
    else        ext_p = WIDTHACC'(bus.i_product);
    base     = (state_q == ST_ACCUM) ? acc_q : '0;
    sum_wide = {1'b0, base} + {1'b0, ext_p};
    if (SIGNED) add_ovf = (base[WIDTHACC-1] == ext_p[WIDTHACC-1]) &&
                          (sum_wide[WIDTHACC-1] != base[WIDTHACC-1]);
    else        add_ovf = sum_wide[WIDTHACC];
    new_acc = sum_wide[WIDTHACC-1:0];
`ifdef PROD_ACCUMULATOR_SAT_EN
    // A signed overflow only happens with like-signed operands, so the
    // partial's sign picks the rail.
    if (add_ovf) begin
      if (SIGNED && base[WIDTHACC-1]) new_acc = SAT_MIN;
      else                            new_acc = SAT_MAX;
    end
`endif
  end

  // FSM, term counter, sticky overflow and output register next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    sum_d       = sum_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q & ~bus.i_out_ready;
    last_term   = (cnt_q == LAST_CNT);
    if (adv) begin
      // IDLE always has cnt=0, so a single-term sum completes from IDLE.
      if (last_term) begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        acc_d       = '0;
        ovf_acc_d   = 1'b0;
        sum_d       = new_acc;
        overflow_d  = ((state_q == ST_ACCUM) & ovf_acc_q) | add_ovf;
        out_valid_d = 1'b1;
      end else begin
        state_d   = ST_ACCUM;
        cnt_d     = cnt_q + 1'b1;
        acc_d     = new_acc;
        ovf_acc_d = ((state_q == ST_ACCUM) & ovf_acc_q) | add_ovf;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clock or posedge i_aclr) begin
    if (i_aclr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.o_clken     = clken;
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_sum       = sum_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_busy      = (state_q == ST_ACCUM) | dly_any;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: directed scenarios plus a randomized run
// scored against an arithmetic reference model.
module tb_prod_accumulator;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  prod_accumulator_if #(.WIDTHP(16), .WIDTHACC(20)) ia ();
  prod_accumulator_if #(.WIDTHP(16), .WIDTHACC(17)) ib ();
  prod_accumulator_if #(.WIDTHP(16), .WIDTHACC(20)) ic ();
  prod_accumulator_if #(.WIDTHP(16), .WIDTHACC(20)) id ();

  prod_accumulator #(.WIDTHP(16), .WIDTHACC(20), .NUM_TERMS(4), .PIPELINE(2), .SIGNED(1'b1))
    u_a (.i_clock(clk), .i_aclr(aclr), .bus(ia));
  prod_accumulator #(.WIDTHP(16), .WIDTHACC(17), .NUM_TERMS(4), .PIPELINE(0), .SIGNED(1'b1))
    u_b (.i_clock(clk), .i_aclr(aclr), .bus(ib));
  prod_accumulator #(.WIDTHP(16), .WIDTHACC(20), .NUM_TERMS(1), .PIPELINE(0), .SIGNED(1'b1))
    u_c (.i_clock(clk), .i_aclr(aclr), .bus(ic));
  prod_accumulator #(.WIDTHP(16), .WIDTHACC(20), .NUM_TERMS(1), .PIPELINE(0), .SIGNED(1'b0))
    u_d (.i_clock(clk), .i_aclr(aclr), .bus(id));

  typedef struct {
    logic [19:0] sum;
    logic        ovf;
  } res_t;

  res_t        exp_q[$];
  longint      m_acc;
  bit          m_ovf;
  int          m_cnt;
  logic [15:0] pipe0, pipe1, a_op;
  bit          a_last_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Add one term with mathematical range checking at width w.
  function automatic void model_step(inout longint acc, inout bit ovf, input longint p,
                                     input int w, input bit sgn);
    longint m, hi, lo, s, r;
    m  = longint'(1) << w;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    lo = sgn ? -(m / 2) : 0;
    s  = acc + p;
    if (s > hi || s < lo) begin
      ovf = 1'b1;
`ifdef PROD_ACCUMULATOR_SAT_EN
      s = (s > hi) ? hi : lo;
`else
      r = (s - lo) % m;
      if (r < 0) r += m;
      s = r + lo;
`endif
    end
    acc = s;
  endfunction

  task automatic model_push(input logic [15:0] p);
    if (m_cnt == 0) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    model_step(m_acc, m_ovf, longint'($signed(p)), 20, 1'b1);
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back('{sum: 20'(m_acc), ovf: m_ovf});
      m_cnt = 0;
    end
  endtask

  // One clock for instance A: models the upstream multiplier pipeline and
  // scores every accepted result.
  task automatic tick_a();
    bit en, iv, ov, rdy;
    logic [19:0] s;
    logic o;
    logic [15:0] op;
    res_t e;
    #1;
    en = ia.o_clken; iv = ia.i_in_valid; ov = ia.o_out_valid; rdy = ia.i_out_ready;
    s = ia.o_sum; o = ia.o_overflow; op = a_op;
    @(posedge clk); #1;
    a_last_en = en;
    if (en) begin
      pipe1 = pipe0;
      pipe0 = op;
      ia.i_product = pipe1;
      if (iv) model_push(op);
    end
    if (ov && rdy) begin
      if (exp_q.size() == 0) check("a_spurious_result", 64'(ov), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("a_sum", 64'(s), 64'(e.sum));
        check("a_ovf", 64'(o), 64'(e.ovf));
      end
    end
  endtask

  task automatic issue_a(input logic [15:0] v);
    int guard;
    guard = 0;
    ia.i_in_valid = 1'b1;
    a_op = v;
    do begin
      tick_a();
      guard++;
    end while (!a_last_en && guard < 64);
    if (!a_last_en) check("a_issue_timeout", 64'(a_last_en), 64'(1));
    ia.i_in_valid = 1'b0;
  endtask

  task automatic idle_a(input int n);
    ia.i_in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick_a();
  endtask

  task automatic wait_valid_a(input string tag);
    int guard;
    guard = 0;
    while (!ia.o_out_valid && guard < 32) begin
      tick_a();
      guard++;
    end
    if (!ia.o_out_valid) check(tag, 64'(ia.o_out_valid), 64'(1));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached in time");
    $fatal(1);
  end

  initial begin
    longint bacc;
    bit     bovf;

    aclr = 1'b1;
    ia.i_clken = 1'b1; ia.i_in_valid = 1'b0; ia.i_product = '0; ia.i_out_ready = 1'b1;
    ib.i_clken = 1'b1; ib.i_in_valid = 1'b0; ib.i_product = '0; ib.i_out_ready = 1'b1;
    ic.i_clken = 1'b1; ic.i_in_valid = 1'b0; ic.i_product = '0; ic.i_out_ready = 1'b1;
    id.i_clken = 1'b1; id.i_in_valid = 1'b0; id.i_product = '0; id.i_out_ready = 1'b1;
    pipe0 = '0; pipe1 = '0; a_op = '0; m_cnt = 0; m_acc = 0; m_ovf = 1'b0; a_last_en = 1'b0;

    // Reset state
    #12;
    check("rst_sum",       64'(ia.o_sum),       64'(0));
    check("rst_out_valid", 64'(ia.o_out_valid), 64'(0));
    check("rst_overflow",  64'(ia.o_overflow),  64'(0));
    check("rst_busy",      64'(ia.o_busy),      64'(0));
    check("rst_clken_hi",  64'(ia.o_clken),     64'(1));
    ia.i_clken = 1'b0; #1;
    check("rst_clken_lo",  64'(ia.o_clken),     64'(0));
    ia.i_clken = 1'b1;
    @(negedge clk); aclr = 1'b0;
    tick();

    // 3 + 5 - 2 + 10
    issue_a(16'd3); issue_a(16'd5); issue_a(16'hFFFE); issue_a(16'd10);
    tick_a();
    check("basic_valid_early", 64'(ia.o_out_valid), 64'(0));
    check("basic_busy",        64'(ia.o_busy),      64'(1));
    tick_a();
    check("basic_valid", 64'(ia.o_out_valid), 64'(1));
    check("basic_sum",   64'(ia.o_sum),       64'(20'd16));
    check("basic_ovf",   64'(ia.o_overflow),  64'(0));
    tick_a();
    check("basic_consumed", 64'(ia.o_out_valid), 64'(0));
    check("basic_idle",     64'(ia.o_busy),      64'(0));

    // Back-pressure: held result freezes the next sum
    ia.i_out_ready = 1'b0;
    issue_a(16'd2); issue_a(16'd2); issue_a(16'd2); issue_a(16'd2);
    issue_a(16'd1); issue_a(16'd1);
    idle_a(3);
    check("stall_clken", 64'(ia.o_clken),     64'(0));
    check("stall_valid", 64'(ia.o_out_valid), 64'(1));
    check("stall_sum",   64'(ia.o_sum),       64'(20'd8));
    idle_a(4);
    check("stall_frozen_sum",  64'(ia.o_sum),  64'(20'd8));
    check("stall_frozen_busy", 64'(ia.o_busy), 64'(1));
    ia.i_out_ready = 1'b1;
    issue_a(16'd1); issue_a(16'd1);
    wait_valid_a("stall_resume_timeout");
    check("stall_resume_sum", 64'(ia.o_sum), 64'(20'd4));
    idle_a(2);

    // Asynchronous clear mid-sum
    issue_a(16'd7); issue_a(16'd7);
    idle_a(2);
    check("aclr_pre_busy", 64'(ia.o_busy), 64'(1));
    aclr = 1'b1; #2;
    check("aclr_sum",   64'(ia.o_sum),       64'(0));
    check("aclr_valid", 64'(ia.o_out_valid), 64'(0));
    check("aclr_ovf",   64'(ia.o_overflow),  64'(0));
    check("aclr_busy",  64'(ia.o_busy),      64'(0));
    check("aclr_clken", 64'(ia.o_clken),     64'(1));
    m_cnt = 0; exp_q.delete(); pipe0 = '0; pipe1 = '0; ia.i_product = '0;
    #2; aclr = 1'b0;
    issue_a(16'd7); issue_a(16'd7); issue_a(16'd7); issue_a(16'd7);
    wait_valid_a("aclr_next_timeout");
    check("aclr_next_sum", 64'(ia.o_sum), 64'(20'd28));
    idle_a(2);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      ia.i_clken     = ($urandom_range(0, 9) != 0);
      ia.i_out_ready = ($urandom_range(0, 9) < 7);
      ia.i_in_valid  = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       a_op = 16'h7FFF;
        1:       a_op = 16'h8000;
        default: a_op = 16'($urandom);
      endcase
      tick_a();
    end
    ia.i_clken = 1'b1; ia.i_out_ready = 1'b1; ia.i_in_valid = 1'b0;
    while (m_cnt != 0) issue_a(16'($urandom));
    for (int i = 0; i < 40 && (exp_q.size() != 0 || ia.o_out_valid || ia.o_busy); i++) tick_a();
    check("rand_all_results_seen", 64'(exp_q.size()), 64'(0));
    check("rand_drained_busy",     64'(ia.o_busy),    64'(0));

    // Overflow at WIDTHACC=17
    ib.i_in_valid = 1'b1; ib.i_product = 16'h7FFF;
    tick(); tick(); tick();
    check("ovf_busy", 64'(ib.o_busy), 64'(1));
    tick();
    ib.i_in_valid = 1'b0;
    check("ovf_valid", 64'(ib.o_out_valid), 64'(1));
`ifdef PROD_ACCUMULATOR_SAT_EN
    check("ovf_sum", 64'(ib.o_sum), 64'(17'h0FFFF));
`else
    check("ovf_sum", 64'(ib.o_sum), 64'(17'h1FFFC));
`endif
    check("ovf_flag", 64'(ib.o_overflow), 64'(1));
    // Negative overflow, expected from the model
    bacc = 0; bovf = 1'b0;
    for (int i = 0; i < 4; i++) model_step(bacc, bovf, -32768, 17, 1'b1);
    ib.i_in_valid = 1'b1; ib.i_product = 16'h8000;
    tick(); tick(); tick(); tick();
    ib.i_in_valid = 1'b0;
    check("ovf_neg_sum",  64'(ib.o_sum),      64'(17'(bacc)));
    check("ovf_neg_flag", 64'(ib.o_overflow), 64'(bovf));
    // Sticky flag clears with the next sum
    ib.i_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ib.i_product = 16'(i);
      tick();
    end
    ib.i_in_valid = 1'b0;
    check("ovf_clear_sum",  64'(ib.o_sum),      64'(17'd10));
    check("ovf_clear_flag", 64'(ib.o_overflow), 64'(0));
    tick();

    // Single-term, no pipeline, signed
    ic.i_in_valid = 1'b1; ic.i_product = 16'hFFFB;
    tick();
    check("n1_valid", 64'(ic.o_out_valid), 64'(1));
    check("n1_sum",   64'(ic.o_sum),       64'(20'hFFFFB));
    check("n1_busy",  64'(ic.o_busy),      64'(0));
    // Completion in the same cycle the previous result is taken
    ic.i_product = 16'd100;
    tick();
    check("b2b_valid1", 64'(ic.o_out_valid), 64'(1));
    check("b2b_sum1",   64'(ic.o_sum),       64'(20'd100));
    ic.i_product = 16'hFF38;
    tick();
    check("b2b_sum2", 64'(ic.o_sum), 64'(20'hFFF38));
    ic.i_out_ready = 1'b0; ic.i_product = 16'd9;
    tick();
    check("b2b_hold_sum",   64'(ic.o_sum),   64'(20'hFFF38));
    check("b2b_hold_clken", 64'(ic.o_clken), 64'(0));
    ic.i_out_ready = 1'b1;
    tick();
    check("b2b_swap_valid", 64'(ic.o_out_valid), 64'(1));
    check("b2b_swap_sum",   64'(ic.o_sum),       64'(20'd9));
    ic.i_in_valid = 1'b0;
    tick();
    check("b2b_drained", 64'(ic.o_out_valid), 64'(0));

    // Single-term, unsigned
    id.i_in_valid = 1'b1; id.i_product = 16'hFFFF;
    tick();
    id.i_in_valid = 1'b0;
    check("uns_valid", 64'(id.o_out_valid), 64'(1));
    check("uns_sum",   64'(id.o_sum),       64'(20'h0FFFF));
    check("uns_ovf",   64'(id.o_overflow),  64'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter WIDTHP, default 16, width of the incoming product.
REQ-002 SHALL have parameter WIDTHACC, default 20, accumulator and output width; WIDTHACC >= WIDTHP.
REQ-003 SHALL have parameter NUM_TERMS, default 4, number of products summed per result; range >= 1.
REQ-004 SHALL have parameter PIPELINE, default 2, upstream multiplier latency in enabled clocks; range >= 0.
REQ-005 SHALL have parameter SIGNED, default 1: 1 means two's-complement product and sum, 0 means unsigned.
REQ-006 i_clock  in  1  clock; all state updates on the rising edge.
REQ-007 i_aclr  in  1  reset, asynchronous, active-high.
REQ-008 i_clken  in  1  upstream clock enable request.
REQ-009 i_in_valid  in  1  operands presented to the multiplier this cycle are valid.
REQ-010 i_product  in  WIDTHP  multiplier result, PIPELINE enabled clocks after its operands.
REQ-011 o_clken  out  1  effective enable; drives the multiplier clken.
REQ-012 o_out_valid  out  1  o_sum holds an unconsumed result.
REQ-013 i_out_ready  in  1  downstream accepts o_sum.
REQ-014 o_sum  out  WIDTHACC  completed sum.
REQ-015 o_overflow  out  1  an overflow occurred while forming o_sum; qualified by o_out_valid.
REQ-016 o_busy  out  1  partial sum pending or valid in flight.

Function
REQ-017 stall = o_out_valid & ~i_out_ready; o_clken = i_clken & ~stall, combinational.
REQ-018 Valid delay line: PIPELINE stages, advances only when o_clken=1; aligned valid av = stage output; PIPELINE=0 gives av = i_in_valid.
REQ-019 FSM states IDLE (cnt=0, no partial) and ACCUM (partial held); transitions only on o_clken=1 with av=1.
REQ-020 IDLE + av: acc <= ext(i_product), cnt <= 1, go ACCUM; if NUM_TERMS=1, complete immediately and stay IDLE.
REQ-021 ACCUM + av: acc <= acc + ext(i_product), cnt <= cnt+1; ext = sign-extend if SIGNED=1, else zero-extend.
REQ-022 Completion on the term with cnt = NUM_TERMS-1: o_sum <= final sum, o_out_valid <= 1 next cycle, acc/cnt cleared, go IDLE.
REQ-023 Overflow: per-addition signed or unsigned out-of-range at WIDTHACC; sticky across one sum, cleared at the start of the next sum.
REQ-024 o_out_valid clears on i_out_ready=1 unless a completion happens in the same cycle, in which case the new result loads and valid stays 1.
REQ-025 While stall=1, delay line, acc, cnt and FSM hold; products for av=0 are ignored.
REQ-026 o_busy = (state=ACCUM) | any delay-line stage set.

Reset
REQ-027 i_aclr=1 SHALL immediately force IDLE, cnt=0, acc=0, delay line=0, o_sum=0, o_out_valid=0, o_overflow=0; a partial sum is discarded mid-operation.
REQ-028 Reset outputs: o_clken = i_clken, o_busy = 0.

Configuration
REQ-029 Macro PROD_ACCUMULATOR_SAT_EN defined: on overflow, acc clamps to the max/min of WIDTHACC (signed or unsigned per SIGNED); o_overflow is still set.
REQ-030 Macro absent: acc wraps modulo 2^WIDTHACC; o_overflow is still set.

Structure
REQ-031 Package prod_acc_pkg SHALL hold the FSM state enum and the saturation limit functions max/min(width, signed).
REQ-032 Sub-module prod_acc_valid_dly SHALL implement the enable-gated valid delay line (parameter PIPELINE).

Verification
REQ-033 Defaults; i_out_ready=1; products 3, 5, -2, 10 with av on consecutive cycles -> o_sum=16, o_out_valid=1 one cycle after the 4th av, o_overflow=0.
REQ-034 WIDTHACC=17, SIGNED=1; four products 32767 -> with macro: o_sum=65535, o_overflow=1; without macro: o_sum=-4, o_overflow=1.
REQ-035 i_out_ready=0 with a result held -> o_clken=0, and the next sum 1+1+1+1 is frozen; raise ready -> first result accepted, then o_sum=4.
REQ-036 Result held, ready=1 in the same cycle the next sum completes -> o_out_valid stays 1, o_sum is the new value, nothing is lost.
REQ-037 i_aclr pulse after 2 of 4 terms -> all outputs 0 immediately; the next 4 products of 7 give o_sum=28.
REQ-038 PIPELINE=0 and NUM_TERMS=1; product -5 with valid -> o_sum=-5 next cycle; SIGNED=0 with product 16'hFFFF -> o_sum=65535.
